// File: rtl/telemetry_pkg.sv
// Shared constants, FSM encoding and helpers for the telemetry framer.
// ASCII codes are named so the byte mux reads like the frame layout.
package telemetry_pkg;

    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_QMARK = 8'h3F;
    localparam logic [7:0] ASC_UP_P  = 8'h50;
    localparam logic [7:0] ASC_LO_P  = 8'h70;
    localparam logic [7:0] ASC_LO_S  = 8'h73;
    localparam logic [7:0] ASC_LO_I  = 8'h69;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LABEL,
        ST_DIGIT,
        ST_DP,
        ST_UNIT,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

    // Bytes in one frame for a given channel/digit/decimal-point layout.
    function automatic int frame_len(int num_ch, int digits, int dp_pos);
        return num_ch * (6 + digits + ((dp_pos > 0) ? 1 : 0)) + (num_ch - 1) + 2;
    endfunction

endpackage

// File: rtl/telemetry_frame_formatter_period_tick.sv
// Free-running period counter; TICK pulses on the last count while enabled.
// Dropping ENABLE parks the counter at zero so a restart gets a full period.
module period_tick #(
    parameter int PERIOD_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    output logic TICK
);

    localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count 0..PERIOD_CYCLES-1 and wrap; hold at zero while disabled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (!ENABLE || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign TICK = ENABLE && (count == LAST);

endmodule

// File: rtl/telemetry_frame_formatter.sv
// Multi-channel ASCII telemetry framer feeding a UART over valid/ready.
// Readings are snapshotted at launch so a frame is internally consistent.
module telemetry_frame_formatter #(
    parameter int NUM_CH        = 2,
    parameter int DIGITS        = 4,
    parameter int DP_POS        = 2,
    parameter int LZ_BLANK      = 0,
    parameter int PERIOD_CYCLES = 1000000
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic                       FRAME_REQ,
    input  logic [NUM_CH*DIGITS*4-1:0] BCD_IN,
    input  logic                       TX_READY,
    output logic                       TX_VALID,
    output logic [7:0]                 TX_DATA,
    output logic                       BUSY,
    output logic                       FRAME_DONE,
    output logic                       OVERRUN
);

    import telemetry_pkg::*;

    localparam int BW = NUM_CH * DIGITS * 4;
    localparam int CW = DIGITS * 4;

    state_t          state, state_nx;
    logic [3:0]      sub_idx, sub_nx;
    logic [3:0]      ch_idx, ch_nx;
    logic [BW-1:0]   snap;
    logic            tick, launch, accept;
    logic [CW-1:0]   cur_ch;
    logic [3:0]      dig_pos, cur_nib;
    logic            lead_zero, blank;

    period_tick #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (START),
        .TICK   (tick)
    );

    assign TX_VALID   = (state != ST_IDLE);
    assign BUSY       = (state != ST_IDLE);
    assign accept     = TX_VALID && TX_READY;
    assign launch     = (state == ST_IDLE) && (tick || FRAME_REQ);
    assign FRAME_DONE = (state == ST_LF) && TX_READY;
    assign dig_pos    = 4'(DIGITS - 1) - sub_idx;

    // Pick the current channel/digit and decide leading-zero blanking.
    always_comb begin
        cur_ch    = '0;
        cur_nib   = '0;
        lead_zero = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) cur_ch = snap[c*CW +: CW];
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (dig_pos == 4'(d)) cur_nib = cur_ch[d*4 +: 4];
            if (4'(d) >= dig_pos && cur_ch[d*4 +: 4] != 4'd0) lead_zero = 1'b0;
        end
        blank = (LZ_BLANK != 0) && (dig_pos > 4'(DP_POS)) && lead_zero;
    end

    // Byte mux: what the current state/sub-index puts on the wire.
    always_comb begin
        TX_DATA = '0;
        unique case (state)
            ST_LABEL: begin
                if (sub_idx == 4'd0)      TX_DATA = ASC_UP_P;
                else if (sub_idx == 4'd1) TX_DATA = ASC_ZERO + 8'd1 + {4'd0, ch_idx};
                else                      TX_DATA = ASC_COLON;
            end
            ST_DIGIT: begin
                if (blank)               TX_DATA = ASC_SPACE;
                else if (cur_nib > 4'd9) TX_DATA = ASC_QMARK;
                else                     TX_DATA = ASC_ZERO + {4'd0, cur_nib};
            end
            ST_DP: TX_DATA = ASC_DOT;
            ST_UNIT: begin
                if (sub_idx == 4'd0)      TX_DATA = ASC_LO_P;
                else if (sub_idx == 4'd1) TX_DATA = ASC_LO_S;
                else                      TX_DATA = ASC_LO_I;
            end
            ST_SEP:  TX_DATA = ASC_SPACE;
            ST_CR:   TX_DATA = ASC_CR;
            ST_LF:   TX_DATA = ASC_LF;
            default: TX_DATA = '0;
        endcase
    end

    // Next-state: launch from IDLE, otherwise advance on each accepted byte.
    always_comb begin
        state_nx = state;
        sub_nx   = sub_idx;
        ch_nx    = ch_idx;
        if (state == ST_IDLE) begin
            if (launch) begin
                state_nx = ST_LABEL;
                sub_nx   = '0;
                ch_nx    = '0;
            end
        end else if (accept) begin
            unique case (state)
                ST_LABEL: begin
                    if (sub_idx == 4'd2) begin
                        state_nx = ST_DIGIT;
                        sub_nx   = '0;
                    end else begin
                        sub_nx = sub_idx + 4'd1;
                    end
                end
                ST_DIGIT: begin
                    if (sub_idx == 4'(DIGITS - 1)) begin
                        state_nx = ST_UNIT;
                        sub_nx   = '0;
                    end else begin
                        sub_nx = sub_idx + 4'd1;
                        if (DP_POS > 0 && dig_pos == 4'(DP_POS)) state_nx = ST_DP;
                    end
                end
                ST_DP: state_nx = ST_DIGIT;
                ST_UNIT: begin
                    if (sub_idx == 4'd2) begin
                        sub_nx   = '0;
                        state_nx = (ch_idx == 4'(NUM_CH - 1)) ? ST_CR : ST_SEP;
                    end else begin
                        sub_nx = sub_idx + 4'd1;
                    end
                end
                ST_SEP: begin
                    state_nx = ST_LABEL;
                    ch_nx    = ch_idx + 4'd1;
                end
                ST_CR:   state_nx = ST_LF;
                ST_LF:   state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM and index registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            sub_idx <= '0;
            ch_idx  <= '0;
        end else begin
            state   <= state_nx;
            sub_idx <= sub_nx;
            ch_idx  <= ch_nx;
        end
    end

    // Snapshot readings at launch; flag ticks lost to a busy framer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            snap    <= '0;
            OVERRUN <= 1'b0;
        end else begin
            if (launch) snap <= BCD_IN;
            if (tick && state != ST_IDLE) OVERRUN <= 1'b1;
        end
    end

endmodule
